bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
- Single-digit BCD source that drives the 7-segment display driver's BCD input.
- Divides the 50 MHz board clock into a periodic step tick and counts one decimal digit, 0-9, up or down.
- Supports synchronous load, a carry/borrow pulse for cascading further digits, and a decimal-point request output.
- Sits directly upstream of the BCD-to-one-digit display driver: bcd feeds the driver's digit input, dp feeds its decimal-point input.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, step rate in Hz.
- DIV, CLK_HZ/TICK_HZ, prescaler period in clocks.
  - Must be >= 1.
  - Overridable directly; bench uses DIV=4.
- PW, $clog2(DIV) (minimum 1), prescaler register width.

Ports:
- clk50MHz  in  1  system clock, 50 MHz; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  4  value to load.
- bcd  out  4  current digit, always 0-9.
- tick  out  1  one-cycle pulse on every step.
- carry  out  1  one-cycle pulse on wrap: 9->0 up, 0->9 down.
- dp  out  1  decimal-point request: 1 = lit; the display driver handles polarity.

Behaviour:
- Clock and reset: one clock (clk50MHz); reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: bcd=0, prescaler pcnt=0, tick=0, carry=0, dp=0. Reset asserted mid-count clears everything immediately, without waiting for a clock edge.
- Prescaler:
  - en=1 and pcnt<DIV-1: pcnt increments.
  - en=1 and pcnt==DIV-1: pcnt returns to 0 and a step occurs.
  - en=0: pcnt holds its value; no step, tick=0.
- Step, on the clock edge where the step condition is true:
  - Up: bcd=bcd+1; 9 wraps to 0 and sets carry=1 for one cycle.
  - Down: bcd=bcd-1; 0 wraps to 9 and sets carry=1 for one cycle.
  - tick=1 for exactly one cycle, on the same edge as the bcd update.
  - Latency: new bcd, tick and carry are all visible together in the cycle after the edge.
- tick and carry are 0 in every cycle without a step. carry never asserts without tick.
- Load (load=1):
  - Highest priority after reset.
  - bcd <= load_val if load_val<=9; load_val 10-15 loads 0.
  - pcnt <= 0; tick=0 and carry=0 that cycle.
  - Applies regardless of en.
  - Load coinciding with a step condition: load wins, step discarded.
- Direction change: up_dn is sampled only at step edges; no effect on pcnt.
- DIV=1: a step occurs on every cycle with en=1 (tick held high while enabled and not loading).
- Invalid states: bcd register values 10-15 are unreachable. If ever present, the next step goes to 0 (up) or 9 (down), with no carry.

Optional Feature:
- Macro: BCD_TICK_DP_BLINK_EN.
- Defined: dp toggles on every tick (steps only, not load); reset value 0; load leaves dp unchanged. Gives a visible 0.5 Hz heartbeat at TICK_HZ=1.
- Undefined: dp is constant 0; the toggle register is not built.

Test Plan (DIV=4):
- Reset: assert rst for 100 ns, release, hold en=1, up_dn=1.
  - During reset: bcd=0, tick=0, carry=0, dp=0.
  - After release: first tick 4 clocks later, bcd=1.
- Up wrap: count up from 0 through ten steps.
  - bcd runs 1..9 then 0.
  - carry=1 only in the cycle bcd becomes 0, coincident with tick.
  - tick period exactly 4 clocks.
- Down wrap: load 0, up_dn=0, en=1.
  - Next tick gives bcd=9 with carry=1.
  - Following ticks give 8, 7 with carry=0.
- Load priority: assert load with load_val=5 on the exact cycle a step is due.
  - bcd=5, tick=0, carry=0.
  - Next tick 4 clocks later gives bcd=6.
  - load_val=12 loads bcd=0.
- Enable hold: drop en for 10 cycles mid-period (pcnt=2).
  - No tick while en=0; bcd unchanged.
  - After en returns, tick comes 2 clocks later.
- Async reset mid-count: assert rst between clock edges while bcd=7.
  - bcd=0 and dp=0 immediately, without waiting for a clock edge.
  - With BCD_TICK_DP_BLINK_EN, before reset: dp toggled on each of the preceding ticks.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// Single-digit BCD up/down counter stepped by a clock prescaler, with load and carry/borrow.
// Optional macro BCD_TICK_DP_BLINK_EN: dp toggles on every step; otherwise dp is tied to 0.
`timescale 1ns/1ps
module bcd_tick_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int DIV     = CLK_HZ / TICK_HZ,
  parameter int PW      = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] bcd,
  output logic       tick,
  output logic       carry,
  output logic       dp
);

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic          step_p0;
  logic          wrap_p0;
  logic [3:0]    bcd_nxt_p0;

  // Out-of-range load values collapse to 0 so bcd always stays a decimal digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > 4'd9) ? 4'd0 : v;
  endfunction

  // Any value at or above 9 steps up to 0; 10-15 never raise carry (see wrap_p0).
  function automatic logic [3:0] digit_up(input logic [3:0] v);
    return (v >= 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dn(input logic [3:0] v);
    return ((v == 4'd0) || (v > 4'd9)) ? 4'd9 : v - 4'd1;
  endfunction

  // Stage p0: step decision and next digit, combinational from current state.
  always_comb begin
    step_p0    = en && (pcnt == PCNT_LAST);
    bcd_nxt_p0 = up_dn ? digit_up(bcd) : digit_dn(bcd);
    wrap_p0    = up_dn ? (bcd == 4'd9) : (bcd == 4'd0);
  end

  // Stage p1: registered digit, prescaler and one-cycle pulses.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      bcd   <= 4'd0;
      pcnt  <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      bcd   <= clamp_digit(load_val);
      pcnt  <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= step_p0;
      carry <= step_p0 && wrap_p0;
      if (step_p0) begin
        bcd  <= bcd_nxt_p0;
        pcnt <= '0;
      end else if (en) begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

`ifdef BCD_TICK_DP_BLINK_EN
  logic dp_q;

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      dp_q <= 1'b0;
    end else if (!load && step_p0) begin
      dp_q <= ~dp_q;
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: directed scenarios at DIV=4 plus random stimulus on DIV=4 and DIV=1 copies.
`timescale 1ns/1ps
module tb_bcd_tick_counter;

  logic       clk50MHz = 1'b0;
  logic       rst      = 1'b0;
  logic       en       = 1'b1;
  logic       up_dn    = 1'b1;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] bcd, bcd1;
  logic       tick, carry, dp, tick1, carry1, dp1;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk50MHz = ~clk50MHz;

  bcd_tick_counter #(.DIV(4)) dut (
    .clk50MHz(clk50MHz), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd(bcd), .tick(tick), .carry(carry), .dp(dp)
  );

  bcd_tick_counter #(.DIV(1)) dut1 (
    .clk50MHz(clk50MHz), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd(bcd1), .tick(tick1), .carry(carry1), .dp(dp1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: digit as an integer mod 10, prescaler as a plain count.
  int divs [2] = '{4, 1};
  int m_bcd [2];
  int m_p   [2];
  bit m_tick [2];
  bit m_carry[2];
  bit m_dp   [2];

  always @(posedge clk50MHz or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_bcd[i] = 0; m_p[i] = 0; m_tick[i] = 0; m_carry[i] = 0; m_dp[i] = 0;
      end else if (load) begin
        m_bcd[i]   = (load_val <= 4'd9) ? int'(load_val) : 0;
        m_p[i]     = 0;
        m_tick[i]  = 0;
        m_carry[i] = 0;
      end else if (en && m_p[i] == divs[i] - 1) begin
        m_p[i]    = 0;
        m_tick[i] = 1;
        if (up_dn) begin
          m_carry[i] = (m_bcd[i] == 9);
          m_bcd[i]   = (m_bcd[i] + 1) % 10;
        end else begin
          m_carry[i] = (m_bcd[i] == 0);
          m_bcd[i]   = (m_bcd[i] + 9) % 10;
        end
        m_dp[i] = !m_dp[i];
      end else begin
        if (en) m_p[i] = m_p[i] + 1;
        m_tick[i]  = 0;
        m_carry[i] = 0;
      end
    end
  end

  function automatic bit exp_dp(input bit d);
`ifdef BCD_TICK_DP_BLINK_EN
    return d;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk50MHz) begin
    check("bcd",    bcd,    m_bcd[0]);
    check("tick",   tick,   m_tick[0]);
    check("carry",  carry,  m_carry[0]);
    check("dp",     dp,     exp_dp(m_dp[0]));
    check("bcd1",   bcd1,   m_bcd[1]);
    check("tick1",  tick1,  m_tick[1]);
    check("carry1", carry1, m_carry[1]);
    check("dp1",    dp1,    exp_dp(m_dp[1]));
  end

  task automatic cyc();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 20);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int  n;
    logic dp_before;

    rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    #100;
    check("rst_bcd", bcd, 0);
    check("rst_tick", tick, 0);
    check("rst_carry", carry, 0);
    check("rst_dp", dp, 0);
    cyc();
    rst = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("first_tick", tick, (k == 4) ? 1 : 0);
    end
    check("first_bcd", bcd, 1);

    for (int s = 2; s <= 10; s++) begin
      wait_tick(n);
      check("up_period", n, 4);
      check("up_bcd", bcd, s % 10);
      check("up_carry", carry, (s == 10) ? 1 : 0);
    end

    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0; up_dn = 1'b0;
    check("load0_bcd", bcd, 0);
    wait_tick(n);
    check("dn_period", n, 4);
    check("dn_bcd9", bcd, 9);
    check("dn_carry9", carry, 1);
    wait_tick(n);
    check("dn_bcd8", bcd, 8);
    check("dn_carry8", carry, 0);
    wait_tick(n);
    check("dn_bcd7", bcd, 7);
    check("dn_carry7", carry, 0);

    up_dn = 1'b1;
    repeat (3) cyc();
    check("pre_load_tick", tick, 0);
    load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0;
    check("ldpri_bcd", bcd, 5);
    check("ldpri_tick", tick, 0);
    check("ldpri_carry", carry, 0);
    wait_tick(n);
    check("ldpri_period", n, 4);
    check("ldpri_next", bcd, 6);

    load = 1'b1; load_val = 4'd12;
    cyc();
    load = 1'b0;
    check("load12_bcd", bcd, 0);

    repeat (2) cyc();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("hold_tick", tick, 0);
      check("hold_bcd", bcd, 0);
    end
    en = 1'b1;
    wait_tick(n);
    check("resume_period", n, 2);
    check("resume_bcd", bcd, 1);

    load = 1'b1; load_val = 4'd6;
    cyc();
    load = 1'b0;
    dp_before = dp;
    wait_tick(n);
    check("pre_rst_bcd", bcd, 7);
`ifdef BCD_TICK_DP_BLINK_EN
    check("dp_toggle", dp, !dp_before);
`endif
    #4;
    rst = 1'b1;
    #1;
    check("async_bcd", bcd, 0);
    check("async_dp", dp, 0);
    check("async_tick", tick, 0);
    cyc();
    rst = 1'b0;

    repeat (3000) begin
      cyc();
      en       = ($urandom_range(0, 7) != 0);
      up_dn    = $urandom_range(0, 1);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
